contador_n_ud: RTL and testbench

- Parametrised modulo-N counter; successor to the fixed 8-bit modulo-N counter.
- Adds generic width, count enable, up/down direction, synchronous parallel load and a cascade carry (tc).
- Adds a one-shot mode driven by a small FSM.
- Used as timebase/prescaler and event counter; tc lets instances chain into wider prescalers.

---
 rtl/contador_n_ud.sv | 114 +++++++++++
 tb/tb_contador_n_ud.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/contador_n_ud.sv
// Parametrised modulo-N up/down counter with synchronous load, cascade carry (tc)
// and an optional one-shot mode sequenced by a small FSM.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | one-shot not armed (always here when oneshot=0)
// ST_RUN   | one-shot armed; counter steps on en until it wraps
// ST_DONE  | one-shot finished; q holds its wrap value until rearmed
module contador_n_ud #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] n,
    input  logic             oneshot,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             wrap,
    output logic             tc,
    output logic             done,
    output logic             busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic             wrap_q, wrap_d;

    logic [WIDTH-1:0] term_m;
    logic [WIDTH-1:0] d_clamped;
    logic             step;
    logic             at_top;
    logic             at_zero;
    logic             tc_c;

    // n=0 naturally yields all-ones, giving the full binary range.
    assign term_m = n - ONE;

    always_comb begin
        step      = en & (~oneshot | (state_q == ST_RUN));
        at_top    = (q_q >= term_m);
        at_zero   = (q_q == '0);
        tc_c      = step & (up_dn ? at_top : at_zero);
        d_clamped = (d > term_m) ? term_m : d;
        q_d       = q_q;
        wrap_d    = 1'b0;
        if (load) begin
            q_d = d_clamped;
        end else if (step) begin
            if (up_dn) begin
                if (at_top) begin
                    q_d    = '0;
                    wrap_d = 1'b1;
                end else begin
                    q_d = q_q + ONE;
                end
            end else begin
                if (at_zero) begin
                    q_d    = term_m;
                    wrap_d = 1'b1;
                end else if (q_q > term_m) begin
                    // modulus was lowered below the current count
                    q_d = term_m;
                end else begin
                    q_d = q_q - ONE;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (!oneshot) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (start)  state_d = ST_RUN;
                ST_RUN:  if (wrap_d) state_d = ST_DONE;
                ST_DONE: if (start)  state_d = ST_RUN;
                default:             state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            q_q     <= '0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_q     <= q_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q    = q_q;
    assign wrap = wrap_q;
    assign tc   = tc_c;
    assign busy = (state_q == ST_RUN);
    assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_contador_n_ud.sv
// Directed self-checking bench for contador_n_ud: free-run, modulus change,
// async reset, down/load/clamp, one-shot, cascade and edge moduli.
module tb_contador_n_ud;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en, up_dn, load, oneshot, start;
    logic [W-1:0] d, n;
    logic [W-1:0] q;
    logic         wrap, tc, done, busy;

    logic         c_en;
    logic [W-1:0] c_n;
    logic [W-1:0] s1_q, s2_q;
    logic         s1_wrap, s1_tc, s1_done, s1_busy;
    logic         s2_wrap, s2_tc, s2_done, s2_busy;

    int checks = 0;
    int errors = 0;

    contador_n_ud #(.WIDTH(W)) u_dut (
        .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .load(load), .d(d), .n(n),
        .oneshot(oneshot), .start(start), .q(q), .wrap(wrap), .tc(tc),
        .done(done), .busy(busy)
    );

    contador_n_ud #(.WIDTH(W)) u_s1 (
        .clk(clk), .rst(rst), .en(c_en), .up_dn(1'b1), .load(1'b0), .d(8'd0), .n(c_n),
        .oneshot(1'b0), .start(1'b0), .q(s1_q), .wrap(s1_wrap), .tc(s1_tc),
        .done(s1_done), .busy(s1_busy)
    );

    contador_n_ud #(.WIDTH(W)) u_s2 (
        .clk(clk), .rst(rst), .en(s1_tc), .up_dn(1'b1), .load(1'b0), .d(8'd0), .n(c_n),
        .oneshot(1'b0), .start(1'b0), .q(s2_q), .wrap(s2_wrap), .tc(s2_tc),
        .done(s2_done), .busy(s2_busy)
    );

    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; oneshot = 1'b0; start = 1'b0;
        d = '0; n = 8'd5; c_en = 1'b0; c_n = 8'd10;
        #25;
        chk("rst_q", q, 0);
        chk("rst_wrap", wrap, 0);
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        en  = 1'b1;
        #1 chk("tc_q0_up", tc, 0);

        // free-run up, n=5
        for (int i = 1; i <= 13; i++) begin
            tick();
            chk("fr_q", q, i % 5);
            chk("fr_wrap", wrap, (i % 5) == 0);
            chk("fr_tc", tc, (i % 5) == 4);
        end

        // q=3: raise modulus to 20
        n = 8'd20;
        for (int i = 4; i <= 19; i++) begin
            tick();
            chk("n20_q", q, i);
            chk("n20_tc", tc, i == 19);
        end
        tick();
        chk("n20_wrap_q", q, 0);
        chk("n20_wrap", wrap, 1);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("n20b_q", q, i);
        end

        // lower modulus below count
        n = 8'd4;
        #1 chk("n4_tc_above", tc, 1);
        tick();
        chk("n4_q", q, 0);
        chk("n4_wrap", wrap, 1);
        tick();
        tick();
        chk("n4_q2", q, 2);

        // async reset pulse between edges
        #5 rst = 1'b1;
        #2 chk("async_rst_q", q, 0);
        chk("async_rst_wrap", wrap, 0);
        rst = 1'b0;
        n   = 8'd100;
        for (int i = 1; i <= 99; i++) begin
            tick();
            chk("n100_q", q, i);
        end
        chk("n100_tc", tc, 1);
        tick();
        chk("n100_wrap_q", q, 0);
        chk("n100_wrap", wrap, 1);

        // down count with load
        up_dn = 1'b0; n = 8'd10; en = 1'b0; load = 1'b1; d = 8'd7;
        tick();
        chk("ld7_q", q, 7);
        load = 1'b0; en = 1'b1;
        for (int i = 6; i >= 0; i--) begin
            tick();
            chk("dn_q", q, i);
            chk("dn_wrap", wrap, 0);
        end
        #1 chk("dn_tc0", tc, 1);
        tick();
        chk("dn_wrap_q", q, 9);
        chk("dn_wrap", wrap, 1);
        load = 1'b1; d = 8'd200;
        tick();
        chk("ld_clamp_q", q, 9);
        chk("ld_clamp_wrap", wrap, 0);
        d = 8'd3;
        tick();
        chk("ld_wins_q", q, 3);
        load = 1'b0; n = 8'd2;
        #1 chk("dn_above_tc", tc, 0);
        tick();
        chk("dn_above_q", q, 1);
        chk("dn_above_wrap", wrap, 0);

        // one-shot, n=4 up
        oneshot = 1'b1; n = 8'd4; up_dn = 1'b1; load = 1'b1; d = 8'd0;
        tick();
        chk("os_ld_q", q, 0);
        chk("os_ld_busy", busy, 0);
        load = 1'b0;
        tick();
        chk("os_idle_q", q, 0);
        chk("os_idle_busy", busy, 0);
        #1 chk("os_idle_tc", tc, 0);
        start = 1'b1;
        tick();
        chk("os_start_busy", busy, 1);
        chk("os_start_q", q, 0);
        start = 1'b0;
        tick();
        chk("os_q1", q, 1);
        tick();
        chk("os_q2", q, 2);
        start = 1'b1;
        tick();
        chk("os_q3", q, 3);
        chk("os_q3_busy", busy, 1);
        chk("os_q3_done", done, 0);
        start = 1'b0;
        #1 chk("os_tc", tc, 1);
        tick();
        chk("os_end_q", q, 0);
        chk("os_end_wrap", wrap, 1);
        chk("os_end_done", done, 1);
        chk("os_end_busy", busy, 0);
        tick();
        chk("os_hold_q", q, 0);
        chk("os_hold_done", done, 1);
        chk("os_hold_wrap", wrap, 0);
        start = 1'b1;
        tick();
        chk("os_rearm_busy", busy, 1);
        chk("os_rearm_done", done, 0);
        chk("os_rearm_q", q, 0);
        start = 1'b0;
        tick();
        chk("os_rearm_q1", q, 1);
        oneshot = 1'b0;
        tick();
        chk("os_off_q", q, 2);
        chk("os_off_busy", busy, 0);
        chk("os_off_done", done, 0);

        // n=1
        n = 8'd1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("n1_q", q, 0);
            chk("n1_wrap", wrap, 1);
        end

        // n=0: full 8-bit range
        n = 8'd0; load = 1'b1; d = 8'd253;
        tick();
        chk("n0_ld_q", q, 253);
        load = 1'b0;
        tick();
        chk("n0_q254", q, 254);
        tick();
        chk("n0_q255", q, 255);
        #1 chk("n0_tc", tc, 1);
        tick();
        chk("n0_wrap_q", q, 0);
        chk("n0_wrap", wrap, 1);

        // cascade: two decade stages
        en = 1'b0;
        c_en = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            tick();
            chk("casc_val", int'(s2_q) * 10 + int'(s1_q), i % 100);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
